// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Unsigned magnitude; 0x80000000 maps to itself.
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] x);
    return x[DIV_W-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [DIV_W-1:0] neg_if(input logic n, input logic [DIV_W-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor if it fits.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic [DIV_W-1:0] quo,
  input  logic [DIV_W-1:0] dvsr,
  output logic [DIV_W-1:0] rem_next,
  output logic [DIV_W-1:0] quo_next
);

  logic [DIV_W:0] rem_sh;
  logic [DIV_W:0] trial;

  // rem < dvsr <= 2^31 keeps rem_sh below 2^32, so bit DIV_W of trial is a true sign.
  assign rem_sh = {rem, quo[DIV_W-1]};
  assign trial  = rem_sh - {1'b0, dvsr};

  // NOTE: every output is assigned on every path, so no latch is inferred.
  always_comb begin
    rem_next = rem_sh[DIV_W-1:0];
    quo_next = {quo[DIV_W-2:0], 1'b0};
    if (!trial[DIV_W]) begin
      rem_next = trial[DIV_W-1:0];
      quo_next = {quo[DIV_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit signed divider: one quotient bit per clock, registered outputs, one-cycle ready pulse.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DIV_W-1:0]     rem;
  logic [DIV_W-1:0]     quo;
  logic [DIV_W-1:0]     dvsr;
  logic                 q_neg;
  logic                 r_neg;
  logic                 dz;
  logic [DIV_W-1:0]     rem_next;
  logic [DIV_W-1:0]     quo_next;

  div_step u_step (
    .rem      (rem),
    .quo      (quo),
    .dvsr     (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // NOTE: sequential state uses nonblocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      dz         <= 1'b0;
      result     <= '0;
      remainder  <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
      busy       <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      if (start) begin
        // Start always wins: any operation in flight is dropped without a ready pulse.
        state <= (divisor == '0) ? DONE : RUN;
        cnt   <= '0;
        rem   <= '0;
        quo   <= mag(dividend);
        dvsr  <= mag(divisor);
        q_neg <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
        r_neg <= dividend[DIV_W-1];
        dz    <= (divisor == '0);
        busy  <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
            if (cnt == DIV_LAST) state <= DONE;
          end
          DONE: begin
            state      <= IDLE;
            busy       <= 1'b0;
            result_rdy <= 1'b1;
            exception  <= dz;
            result     <= dz ? '0 : neg_if(q_neg, quo);
            remainder  <= dz ? '0 : neg_if(r_neg, rem);
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: arithmetic reference model, per-cycle scoreboard, literal checks.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] result;
  logic [31:0] remainder;
  logic        exception;
  logic        result_rdy;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .result     (result),
    .remainder  (remainder),
    .exception  (exception),
    .result_rdy (result_rdy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed division with truncation toward zero; remainder takes the dividend's sign.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic e);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; e = 1'b0;
    end else begin
      q = sa / sb; r = sa % sb; e = 1'b0;
    end
  endfunction

  // Scoreboard: pending operation, its due cycle, and the values the outputs must hold.
  int          cyc = 0;
  int          due = 0;
  bit          pend = 1'b0;
  bit          chk_en = 1'b0;
  int          rdy_count = 0;
  logic [31:0] p_q, p_r;
  logic        p_e;
  logic [31:0] h_q = '0, h_r = '0;
  logic        h_e = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (clr_n === 1'b1 && start === 1'b1) begin
      model(dividend, divisor, p_q, p_r, p_e);
      due  = cyc + ((divisor == 32'd0) ? 1 : 33);
      pend = 1'b1;
    end
  end

  always @(negedge clr_n) begin
    pend = 1'b0;
    h_q  = '0;
    h_r  = '0;
    h_e  = 1'b0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_rdy;
      exp_rdy = pend && (cyc == due);
      check("sb_rdy", {31'd0, result_rdy}, {31'd0, exp_rdy});
      check("sb_busy", {31'd0, busy}, {31'd0, pend && (cyc < due)});
      if (result_rdy === 1'b1) rdy_count++;
      if (exp_rdy) begin
        h_q  = p_q;
        h_r  = p_r;
        h_e  = p_e;
        pend = 1'b0;
      end
      check("sb_result", result, h_q);
      check("sb_remainder", remainder, h_r);
      check("sb_exception", {31'd0, exception}, {31'd0, h_e});
    end
  end

  // Drive one operation at the current negedge, wait for ready, check literals and latency.
  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic ee, input int lat);
    int n;
    bit seen;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    n     = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (result_rdy === 1'b1) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check({name, "_rdy_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_latency"}, n, lat);
      check({name, "_result"}, result, eq);
      check({name, "_remainder"}, remainder, er);
      check({name, "_exception"}, {31'd0, exception}, {31'd0, ee});
    end
  endtask

  initial begin
    logic [31:0] mq, mr;
    logic        me;
    int          rc;

    // Pin the reference model with hand-computed values.
    model(32'd100, 32'd7, mq, mr, me);
    check("model_100_7_q", mq, 32'd14);
    check("model_100_7_r", mr, 32'd2);
    model(32'hFFFF_FF9C, 32'd7, mq, mr, me);
    check("model_m100_7_r", mr, 32'hFFFF_FFFE);
    model(32'h8000_0000, 32'hFFFF_FFFF, mq, mr, me);
    check("model_ovf_q", mq, 32'h8000_0000);

    clr_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_flags", {29'd0, exception, result_rdy, busy}, 32'd0);
    clr_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Consecutive runs start in the ready cycle of the previous one.
    run("pos_pos",  32'd100,       32'd7,          32'd14,        32'd2,         1'b0, 33);
    run("neg_pos",  32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    run("pos_neg",  32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2, 32'd2,         1'b0, 33);
    run("div_zero", 32'd1234,      32'd0,          32'd0,         32'd0,         1'b1, 1);
    run("after_dz", 32'd9,         32'd3,          32'd3,         32'd0,         1'b0, 33);
    run("ovf",      32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 33);
    run("max_by_1", 32'h7FFF_FFFF, 32'd1,          32'h7FFF_FFFF, 32'd0,         1'b0, 33);
    run("neg_neg",  32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 1'b0, 33);
    run("small",    32'd7,         32'd100,        32'd0,         32'd7,         1'b0, 33);
    run("min_by_2", 32'h8000_0000, 32'd2,          32'hC000_0000, 32'd0,         1'b0, 33);

    // Restart: 50/5 is dropped by 81/9 ten cycles later; only one ready pulse.
    repeat (3) @(negedge clk);
    rc = rdy_count;
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    run("restart", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33);
    repeat (5) @(negedge clk);
    check("restart_one_rdy", rdy_count - rc, 1);

    // Reset mid-operation: outputs clear immediately and no ready ever follows.
    rc = rdy_count;
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("midreset_result", result, 32'd0);
    check("midreset_remainder", remainder, 32'd0);
    check("midreset_flags", {29'd0, exception, result_rdy, busy}, 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset_no_rdy", rdy_count - rc, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit signed divider that computes the quotient and remainder one bit per clock, and presents them with a one-cycle ready pulse. It sits directly upstream of the processor's 32-bit divide-result register. Its `result` drives that register's data input, and `result_rdy` drives its write enable. The ALU/multdiv control issues a start pulse and stalls until `result_rdy`.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported and verified.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  single-cycle request; samples `dividend` and `divisor` on the same edge.
- `dividend`  in  32  two's-complement dividend.
- `divisor`  in  32  two's-complement divisor.
- `result`  out  32  signed quotient; holds until the next completion.
- `remainder`  out  32  signed remainder; its sign follows the dividend.
- `exception`  out  1  high with `result_rdy` when the divisor is 0; holds with `result`.
- `result_rdy`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in states RUN and DONE.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs 32 iterations, with a 5-bit counter running 0..31.
  - DONE: performs sign fix-up and the output write.
- On `start`, from any state:
  - latch `|dividend|` into the quotient shift register and `|divisor|` into `dvsr`;
  - clear the partial remainder;
  - store `q_neg = dividend[31] ^ divisor[31]` and `r_neg = dividend[31]`.
  - Start is always accepted. An active operation is aborted and restarted.
- Divisor of 0 at start: go to DONE directly with the zero-divide flag set. No iterations are run.
- RUN iteration (restoring division):
  - `{rem,quo} <= {rem,quo} << 1`;
  - compute `trial = rem_shifted - dvsr` in 33 bits;
  - if `trial` is non-negative, `rem <= trial` and `quo[0] <= 1`.
  - After the iteration with count = 31, go to DONE.
- DONE → IDLE:
  - register `result = q_neg ? -quo : quo` and `remainder = r_neg ? -rem : rem`;
  - `exception` = zero-divide flag;
  - pulse `result_rdy`.
  - On divide-by-zero: `result` = 0, `remainder` = 0, `exception` = 1.
- Magnitudes use 32-bit unsigned arithmetic, so `|0x80000000|` = `0x80000000`.
- 0x80000000 / −1 wraps to 0x80000000 with remainder 0 and `exception` = 0.
- `exception` is cleared on the next successful completion. It is not cleared by `start`.

## Timing
- Reset values: state IDLE, counter 0, `result` 0, `remainder` 0, `exception` 0, `result_rdy` 0, `busy` 0.
- Reset asserted mid-operation aborts immediately with no `result_rdy`.
- Normal latency:
  - edge E0 samples `start`;
  - edges E1..E32 perform the iterations;
  - edge E33 writes the outputs.
  - `result_rdy` is high for exactly the cycle after E33.
- Divide-by-zero latency: `result_rdy` is high for the cycle after E1.
- `start` in the same cycle as `result_rdy` is accepted; the next result follows 33 edges later.
- `start` while `busy`: the old operation is dropped. No `result_rdy` is produced for it, and the outputs keep their previous values.
- `result`, `remainder` and `exception` change only on the `result_rdy` edge or on reset.

## Structure
- Package `div_pkg` holds:
  - state encoding `div_state_t` (IDLE, RUN, DONE);
  - `DIV_W` = 32 and `DIV_CNT_W` = 5;
  - `DIV_LAST` = 31.
- Sub-module `div_step`: combinational single iteration, taking rem, quo and dvsr and returning next rem and next quo. It is instantiated once.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- 100 / 7 → `result` 14, `remainder` 2, `exception` 0; `result_rdy` exactly 33 edges after start, one cycle wide.
- −100 / 7 → `result` 0xFFFFFFF2, `remainder` 0xFFFFFFFE.
- 100 / −7 → `result` 0xFFFFFFF2, `remainder` 2.
- 1234 / 0 → `result` 0, `remainder` 0, `exception` 1 after 1 cycle.
- A following 9 / 3 → `result` 3, `exception` 0.
- 0x80000000 / 0xFFFFFFFF → `result` 0x80000000, `exception` 0.
- 0x7FFFFFFF / 1 → `result` 0x7FFFFFFF.
- Restart and reset:
  - Start 50 / 5, then start 81 / 9 at cycle 10 → a single `result_rdy`, 33 edges after the second start, with `result` 9.
  - Drop `clr_n` at cycle 20 of an operation → all outputs 0, `busy` 0, no `result_rdy`.
